// File: rtl/rom_burst_reader_if.sv
// Output stream bundle for rom_burst_reader: valid/ready handshake carrying
// one ROM data word per beat plus a last-beat marker.
interface rom_burst_reader_if #(
   parameter int DATA_W = 4
);

   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   // Producer side: the burst reader drives the beat, the consumer drives ready.
   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   // Consumer side: sees the beat, returns ready.
   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/rom_burst_reader.sv
// Burst sequencer for a small lookup ROM.
// A command (start address, length) is accepted while idle.
// The reader then walks the ROM address port, wrapping at DEPTH.
// Each combinational read is registered into an output beat, which is
// presented downstream as a valid/ready stream with a last flag.
module rom_burst_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   rom_burst_reader_if.master out_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One extra bit so DEPTH can equal 2**ADDR_W without overflowing.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [LEN_W-1:0]  ONE_LEFT  = LEN_W'(1);

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              valid_q,     valid_d;
   logic [DATA_W-1:0] data_q,      data_d;
   logic              last_q,      last_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;

   logic              addr_ok;
   logic              slot_free;
   logic              handshake;
   logic [ADDR_W-1:0] addr_next;

   assign addr_ok   = ({1'b0, start_addr} < DEPTH_EXT);
   assign handshake = valid_q && out_if.out_ready;
   assign slot_free = !valid_q || out_if.out_ready;
   assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

   // Register every piece of state; reset aborts any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         last_q      <= last_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state and datapath updates; done/err are single-cycle pulses by default.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      valid_d     = valid_q;
      data_d      = data_q;
      last_d      = last_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (!addr_ok) begin
                  err_d = 1'b1;
               end else if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d      = start_addr;
                  remaining_d = burst_len;
                  state_d     = READ;
               end
            end
         end

         READ: begin
            // A new beat may be loaded only when the output register is empty
            // or its current beat is leaving this cycle.
            if (slot_free) begin
               data_d      = rom_data;
               valid_d     = 1'b1;
               last_d      = (remaining_q == ONE_LEFT);
               addr_d      = addr_next;
               remaining_d = remaining_q - ONE_LEFT;
               if (remaining_q == ONE_LEFT) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (handshake) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy             = (state_q != IDLE);
   assign done             = done_q;
   assign err              = err_q;
   assign rom_addr         = addr_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_last  = last_q;

endmodule
